// File: rtl/ir_fir_scheduler_pkg.sv
// Shared FIR_IR definitions: scheduler state encodings
// and the sample/result widths used by FIR_IR and its scheduler.
package ir_fir_scheduler_pkg;

    localparam int FIR_DW = 8;
    localparam int FIR_OW = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/ir_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after
// ptr (cyclic) and returns it as one-hot grant plus index.
module ir_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    logic found;

    // Scan channels starting at ptr and take the first one requesting
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            logic [CH_W-1:0] cand;
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/ir_fir_scheduler.sv
// Shares one FIR_IR filter among NUM_CH IR channels: grant,
// flush the filter, hold the sample SETTLE cycles, capture.
module ir_fir_scheduler
    import ir_fir_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int SETTLE = 16,
    parameter int DW     = FIR_DW,
    parameter int OW     = FIR_OW
) (
    input  logic                 CLK_Filter,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*DW-1:0] ch_sample,
    output logic [NUM_CH-1:0]    ch_ack,
    output logic [DW-1:0]        fir_in,
    output logic                 fir_rst_n,
    input  logic [OW-1:0]        fir_out,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_ch,
    output logic [OW-1:0]        res_data,
    output logic                 busy
);

    localparam int CNT_W = $clog2(SETTLE) + 1;

    sched_state_e state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [DW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [CH_W-1:0]  res_ch_q, res_ch_d;
    logic [OW-1:0]    res_data_q, res_data_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;
    logic [DW-1:0]     sel_sample;

    ir_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req (ch_req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign sel_sample = ch_sample[arb_idx*DW +: DW];

    // Grant pulse only while idle and out of reset
    assign ch_ack    = (rst_n && state_q == ST_IDLE) ? arb_gnt : '0;
    assign fir_in    = hold_q;
    assign fir_rst_n = rst_n & (state_q != ST_FLUSH);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;

    // Next-state and datapath updates for one filter job
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    hold_d  = sel_sample;
                    grant_d = arb_idx;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                res_data_d  = fir_out;
                res_ch_d    = grant_q;
                res_valid_d = 1'b1;
                if (grant_q == CH_W'(NUM_CH - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = grant_q + CH_W'(1);
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset
    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule

// File: tb/tb_ir_fir_scheduler.sv
// Bench for ir_fir_scheduler with a behavioural 16-tap FIR_IR
// (coefficients 1..16, so golden(x) = 136*x for constant input).
module tb_ir_fir_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int SETTLE = 16;
    localparam int DW     = 8;
    localparam int OW     = 20;
    localparam int LAT    = SETTLE + 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH*DW-1:0] ch_sample;
    logic [NUM_CH-1:0]    ch_ack;
    logic [DW-1:0]        fir_in;
    logic                 fir_rst_n;
    logic [OW-1:0]        fir_out;
    logic                 res_valid;
    logic [CH_W-1:0]      res_ch;
    logic [OW-1:0]        res_data;
    logic                 busy;

    always #5 clk = ~clk;

    ir_fir_scheduler #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .SETTLE (SETTLE),
        .DW     (DW),
        .OW     (OW)
    ) dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .ch_req     (ch_req),
        .ch_sample  (ch_sample),
        .ch_ack     (ch_ack),
        .fir_in     (fir_in),
        .fir_rst_n  (fir_rst_n),
        .fir_out    (fir_out),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .busy       (busy)
    );

    // Behavioural FIR_IR: shift register with sync active-low reset
    logic [DW-1:0] taps [SETTLE];

    always @(posedge clk) begin
        if (!fir_rst_n) begin
            for (int i = 0; i < SETTLE; i++) taps[i] <= '0;
        end else begin
            taps[0] <= fir_in;
            for (int i = 1; i < SETTLE; i++) taps[i] <= taps[i-1];
        end
    end

    always_comb begin
        fir_out = '0;
        for (int i = 0; i < SETTLE; i++) begin
            fir_out = fir_out + OW'(taps[i]) * OW'(i + 1);
        end
    end

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int ack_seen = 0;
    bit flush_pending = 1'b0;

    logic [NUM_CH-1:0] exp_ack_q [$];
    logic [CH_W-1:0]   exp_ch_q  [$];
    logic [OW-1:0]     exp_dat_q [$];
    int                ack_cyc_q [$];

    task automatic check(input bit ok, input string nm,
                         input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares grants and results against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            ack_cyc_q.delete();
            flush_pending = 1'b0;
        end else begin
            if (flush_pending) begin
                check(!fir_rst_n && busy, "flush_rst", 32'(fir_rst_n), 0);
                flush_pending = 1'b0;
            end
            if (ch_ack != '0) begin
                logic [NUM_CH-1:0] ea;
                ack_seen++;
                if (exp_ack_q.size() == 0) begin
                    check(1'b0, "ack_unexpected", 32'(ch_ack), 0);
                end else begin
                    ea = exp_ack_q.pop_front();
                    check(ch_ack == ea, "ack_onehot", 32'(ch_ack), 32'(ea));
                end
                ack_cyc_q.push_back(cyc);
                flush_pending = 1'b1;
            end
            if (res_valid) begin
                if (exp_dat_q.size() == 0) begin
                    check(1'b0, "res_unexpected", 32'(res_data), 0);
                end else begin
                    logic [CH_W-1:0] ec;
                    logic [OW-1:0]   ed;
                    int a;
                    ec = exp_ch_q.pop_front();
                    ed = exp_dat_q.pop_front();
                    check(res_ch == ec, "res_ch", 32'(res_ch), 32'(ec));
                    check(res_data == ed, "res_data", 32'(res_data), 32'(ed));
                    a = (ack_cyc_q.size() != 0) ? ack_cyc_q.pop_front() : -100;
                    check(cyc - a == LAT, "res_latency", 32'(cyc - a), LAT);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int ch, input logic [DW-1:0] v);
        ch_sample[ch*DW +: DW] = v;
    endtask

    task automatic expect_job(input logic [NUM_CH-1:0] a,
                              input logic [CH_W-1:0] c, input logic [OW-1:0] d);
        exp_ack_q.push_back(a);
        exp_ch_q.push_back(c);
        exp_dat_q.push_back(d);
    endtask

    task automatic wait_acks(input int target);
        int t = 0;
        while (ack_seen < target && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (ack_seen < target) check(1'b0, "ack_timeout", 32'(ack_seen), 32'(target));
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            tick(1);
            t++;
        end
        if (busy) check(1'b0, "idle_timeout", 1, 0);
        tick(2);
        check(exp_dat_q.size() == 0, "drain", 32'(exp_dat_q.size()), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ch_req    = '0;
        ch_sample = '0;

        // Reset state
        tick(3);
        check(ch_ack == '0, "rst_ack", 32'(ch_ack), 0);
        check(fir_in == '0, "rst_fir_in", 32'(fir_in), 0);
        check(!res_valid, "rst_valid", 32'(res_valid), 0);
        check(res_ch == '0, "rst_res_ch", 32'(res_ch), 0);
        check(res_data == '0, "rst_res_data", 32'(res_data), 0);
        check(!busy, "rst_busy", 32'(busy), 0);
        check(!fir_rst_n, "rst_fir_rst", 32'(fir_rst_n), 0);
        rst_n = 1'b1;
        tick(1);
        check(fir_rst_n, "rel_fir_rst", 32'(fir_rst_n), 1);

        // Single request on ch1
        set_sample(1, 8'd200);
        expect_job(4'b0010, 2'd1, 20'd27200);
        ch_req = 4'b0010;
        wait_acks(1);
        ch_req = '0;
        wait_idle();

        // Reset mid-SETTLE on a ch2 job (ptr is 2 here)
        set_sample(2, 8'd50);
        exp_ack_q.push_back(4'b0100);
        ch_req = 4'b0100;
        wait_acks(2);
        ch_req = '0;
        tick(6);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check(!busy, "abort_busy", 32'(busy), 0);
            check(!fir_rst_n, "abort_fir_rst", 32'(fir_rst_n), 0);
            check(!res_valid, "abort_valid", 32'(res_valid), 0);
        end
        rst_n = 1'b1;
        tick(1);

        // All request: order 0,1,2,3 proves ptr returned to 0
        set_sample(0, 8'd200);
        set_sample(1, 8'd100);
        set_sample(2, 8'd50);
        set_sample(3, 8'd0);
        expect_job(4'b0001, 2'd0, 20'd27200);
        expect_job(4'b0010, 2'd1, 20'd13600);
        expect_job(4'b0100, 2'd2, 20'd6800);
        expect_job(4'b1000, 2'd3, 20'd0);
        ch_req = 4'b1111;
        wait_acks(6);
        ch_req = '0;
        wait_idle();

        // Wrap: service ch2 so ptr=3, then req 1001 -> ch3, ch0
        expect_job(4'b0100, 2'd2, 20'd6800);
        ch_req = 4'b0100;
        wait_acks(7);
        ch_req = '0;
        wait_idle();
        set_sample(3, 8'd100);
        expect_job(4'b1000, 2'd3, 20'd13600);
        expect_job(4'b0001, 2'd0, 20'd27200);
        ch_req = 4'b1001;
        wait_acks(9);
        ch_req = '0;
        wait_idle();

        // Sample change one cycle after ack is ignored
        set_sample(0, 8'd200);
        expect_job(4'b0001, 2'd0, 20'd27200);
        ch_req = 4'b0001;
        wait_acks(10);
        set_sample(0, 8'd100);
        ch_req = '0;
        wait_idle();
        check(fir_in == 8'd200, "fir_in_hold", 32'(fir_in), 200);

        // Flush: ch0 at 200 then ch1 at 100 leaves no residue
        set_sample(0, 8'd200);
        set_sample(1, 8'd100);
        expect_job(4'b0001, 2'd0, 20'd27200);
        ch_req = 4'b0001;
        wait_acks(11);
        ch_req = '0;
        expect_job(4'b0010, 2'd1, 20'd13600);
        ch_req = 4'b0010;
        wait_acks(12);
        ch_req = '0;
        wait_idle();
        check(fir_in == 8'd100, "fir_in_last", 32'(fir_in), 100);
        check(res_data == 20'd13600, "res_held", 32'(res_data), 13600);
        check(exp_ack_q.size() == 0, "ack_drain", 32'(exp_ack_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
